alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 4-bit ALU (ports a/b/sel in, result/carry out) between two requesters.
- Round-robin arbitration with a valid/ready handshake on the request side.
- Registers the operands that drive the ALU and captures the ALU outputs.
- Returns a tagged, single-cycle response pulse.
- Sits between the two operand-producing blocks and the `alu_4bit` instance, which is instantiated outside this block.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- CNT_W, 8, width of the grant counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  2  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as above, for requester 1.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_sel  out  2  registered opcode to the ALU.
- alu_result  in  WIDTH  ALU result; combinational from alu_a/alu_b/alu_sel.
- alu_carry  in  1  ALU carry/borrow.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_carry  out  1  captured ALU carry.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is asynchronous and active-low (rst_n); single clock (clk). While rst_n=0:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - alu_a=alu_b=0, alu_sel=00.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, busy=0.
- ALU opcode encoding (pass-through, not decoded here): 00 add, 01 sub, 10 AND, 11 OR.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner: if only one valid, that requester; if both valid, the one not equal to last_grant.
  - readyN is combinational: readyN = (state==IDLE) && (winner==N). The ready of the non-winner stays 0.
  - The handshake occurs on the edge where valid&ready=1. On that edge, latch the winner's a/b/sel into alu_a/alu_b/alu_sel, latch the id, set last_grant=id, and go to EXEC.
  - With no valid request, stay in IDLE; alu_* hold their previous values (no toggling).
- EXEC: one full cycle for the ALU to settle. On the exiting edge, capture alu_result/alu_carry into rsp_result/rsp_carry, set rsp_id, set rsp_valid=1, and go to RESP.
- RESP:
  - rsp_valid is high for exactly this cycle.
  - On the next edge, clear rsp_valid and return to IDLE.
  - rsp_result/rsp_carry/rsp_id hold their values until the next capture.
- Timing:
  - Latency: handshake at edge k -> rsp_valid high from edge k+1 to edge k+2.
  - Throughput: one accept per 3 cycles at most.
  - Both readys are 0 in EXEC and RESP.
- The response path has no backpressure; the consumer must sample rsp_* while rsp_valid=1.
- Requester inputs are sampled only at the handshake. Changes after acceptance do not affect the in-flight op.
- Requester deasserting valid before ready: the request is not accepted, and last_grant is unchanged.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values; the in-flight op is dropped and no rsp_valid pulse is produced.
- Width: results are WIDTH bits plus carry exactly as the ALU produces them; no extension or saturation.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (out, CNT_W bits each).
  - Each counter increments on every handshake of its requester and wraps from 2^CNT_W-1 to 0.
  - Both reset to 0 asynchronously.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single add: req0 a=3, b=2, sel=00 alone -> req0_ready=1 in IDLE; one cycle after the handshake, rsp_valid=1 for 1 cycle with rsp_id=0, rsp_result=5, rsp_carry=0.
- Tie, round-robin: both valid from reset (req0 a=4, b=1, sel=01; req1 a=12, b=10, sel=10) -> req0 is served first (result 3, id 0), then req1 (result 8, id 1). On the next tie, req0 wins again because last_grant=1.
- Carry/overflow: req1 a=12, b=10, sel=00 -> rsp_result=6, rsp_carry=1, rsp_id=1. OR op a=12, b=10, sel=11 -> rsp_result=14.
- Back-to-back: req1 held valid continuously with req0 idle -> handshakes exactly every 3 cycles; ready=0 and busy=1 during EXEC/RESP.
- Reset mid-op: rst_n pulled low during EXEC -> all outputs 0 immediately, no rsp_valid pulse. After release, the next request completes normally.
- Stats (ALU_ARB_STATS_EN): 3 req0 and 2 req1 handshakes -> grant_cnt0=3, grant_cnt1=2. With CNT_W=2, 4 req0 grants -> grant_cnt0 wraps to 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external 4-bit ALU between two requesters.
// Optional per-requester grant counters are enabled with ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: a request is accepted on the rising edge where reqN_valid && reqN_ready.
  // ready is combinational and only ever high for the IDLE-state winner.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             busy_q, busy_d;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
`endif
  logic             win_any, win_id;

  always_comb begin
    win_any = req0_valid | req1_valid;
    // On a tie the requester that was not granted last time wins.
    win_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && win_any && !win_id;
  assign req1_ready = (state_q == IDLE) && win_any && win_id;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
`ifdef ALU_ARB_STATS_EN
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          alu_a_d   = win_id ? req1_a   : req0_a;
          alu_b_d   = win_id ? req1_b   : req0_b;
          alu_sel_d = win_id ? req1_sel : req0_sel;
          id_d      = win_id;
          last_d    = win_id;
          state_d   = EXEC;
`ifdef ALU_ARB_STATS_EN
          if (win_id) cnt1_d = cnt1_q + 1'b1;
          else        cnt0_d = cnt0_q + 1'b1;
`endif
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      cnt0_q       <= '0;
      cnt1_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      busy_q       <= busy_d;
`ifdef ALU_ARB_STATS_EN
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;
`ifdef ALU_ARB_STATS_EN
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: vector table, directed corner sequences and a
// randomized run against a cycle-count reference model; ALU_ARB_STATS_EN adds counter checks.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req0_sel = '0, req1_sel = '0;
  logic [3:0] alu_a, alu_b, alu_result, rsp_result;
  logic [1:0] alu_sel, dbg_state;
  logic       alu_carry, rsp_valid, rsp_id, rsp_carry, busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];

  alu_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Stand-in for the external 4-bit ALU.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      2'b00: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      2'b10: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  // Reference result {carry, result} computed with integer arithmetic.
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    int ia, ib, d;
    ia = int'(a);
    ib = int'(b);
    case (s)
      2'b00: begin d = ia + ib; return {d > 15, 4'(d % 16)}; end
      2'b01: begin d = ia - ib; return {d < 0, 4'((d + 16) % 16)}; end
      2'b10: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = s; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = s; end
  endtask

  task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                        input logic [3:0] er, input logic ec, input string tag);
    int waited = 0;
    @(negedge clk);
    set_req(id, 1'b1, a, b, s);
    #1;
    while (!(id ? req1_ready : req0_ready) && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 10) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      set_req(id, 1'b0, a, b, s);
      return;
    end
    chk({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    set_req(id, 1'b0, 4'h0, 4'h0, 2'b00);
    #1;
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_ready"}, {req0_ready, req1_ready}, 0);
    chk({tag, "_exec_rspv"}, rsp_valid, 0);
    chk({tag, "_alu_ops"}, {alu_a, alu_b, alu_sel}, {a, b, s});
    @(negedge clk);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, id);
    chk({tag, "_rsp_result"}, rsp_result, er);
    chk({tag, "_rsp_carry"}, rsp_carry, ec);
    @(negedge clk);
    chk({tag, "_rsp_clear"}, rsp_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  typedef struct {
    logic       id;
    logic [3:0] a, b;
    logic [1:0] sel;
    logic [3:0] exp_r;
    logic       exp_c;
  } vec_t;

  vec_t vecs[7];
  int   hs[$];
  int   next_free, rsp_due, n_g0, n_g1;
  logic last_g, v0, v1, w;
  logic [4:0] e;

  initial begin
    vecs[0] = '{1'b0, 4'd3,  4'd2,  2'b00, 4'd5,  1'b0};
    vecs[1] = '{1'b1, 4'd12, 4'd10, 2'b00, 4'd6,  1'b1};
    vecs[2] = '{1'b1, 4'd12, 4'd10, 2'b11, 4'd14, 1'b0};
    vecs[3] = '{1'b0, 4'd12, 4'd10, 2'b10, 4'd8,  1'b0};
    vecs[4] = '{1'b0, 4'd4,  4'd1,  2'b01, 4'd3,  1'b0};
    vecs[5] = '{1'b1, 4'd1,  4'd4,  2'b01, 4'd13, 1'b1};
    vecs[6] = '{1'b0, 4'd15, 4'd1,  2'b00, 4'd0,  1'b1};

    // reset values
    @(negedge clk);
    #1;
    chk("rst_outputs", {alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, rsp_carry, busy}, 0);
    chk("rst_state", dbg_state, 0);
    do_reset();

    // vector table
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_r, vecs[i].exp_c,
             $sformatf("vec%0d", i));

    // tie from reset: req0 first, then req1, then req0 again
    do_reset();
    set_req(0, 1'b1, 4'd4, 4'd1, 2'b01);
    set_req(1, 1'b1, 4'd12, 4'd10, 2'b10);
    #1;
    chk("tie1_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("tie1_exec_ready", req1_ready, 0);
    @(negedge clk);
    chk("tie1_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry}, {1'b1, 1'b0, 4'd3, 1'b0});
    @(negedge clk); #1;
    chk("tie2_ready", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("tie2_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry}, {1'b1, 1'b1, 4'd8, 1'b0});
    @(negedge clk);
    set_req(0, 1'b1, 4'd1, 4'd1, 2'b00);
    set_req(1, 1'b1, 4'd2, 4'd2, 2'b00);
    #1;
    chk("tie3_ready", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // dropping valid before the edge must not move the round-robin pointer
    @(negedge clk);
    set_req(0, 1'b1, 4'd1, 4'd1, 2'b00);
    set_req(1, 1'b1, 4'd2, 4'd2, 2'b00);
    #1;
    chk("tie_withdraw_ready", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // back-to-back req1
    @(negedge clk);
    set_req(1, 1'b1, 4'd7, 4'd1, 2'b00);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (req1_ready) hs.push_back(i);
      chk($sformatf("b2b_busy_%0d", i), busy, !req1_ready);
      chk($sformatf("b2b_r0_%0d", i), req0_ready, 0);
    end
    req1_valid = 1'b0;
    chk("b2b_hs_count", hs.size(), 5);
    for (int i = 1; i < hs.size(); i++)
      chk($sformatf("b2b_gap_%0d", i), hs[i] - hs[i-1], 3);
    repeat (3) @(negedge clk);

    // reset during EXEC
    set_req(0, 1'b1, 4'd9, 4'd5, 2'b00);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("midrst_in_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_zero", {alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, rsp_carry, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_norsp_%0d", i), {rsp_valid, busy}, 0);
    end
    run_op(0, 4'd9, 4'd5, 2'b00, 4'd14, 1'b0, "after_rst");

    // randomized run against a timing/arbitration model
    do_reset();
    last_g = 1'b1; next_free = 0; rsp_due = -1; n_g0 = 0; n_g1 = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == rsp_due) begin
        chk("rnd_rsp_valid", rsp_valid, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rnd_rsp", {rsp_id, rsp_carry, rsp_result}, {last_g, e});
        end
      end else begin
        chk("rnd_no_rsp", rsp_valid, 0);
      end
      v0 = (cyc < 396) && ($urandom_range(0, 2) == 0);
      v1 = (cyc < 396) && ($urandom_range(0, 2) == 0);
      set_req(0, v0, 4'($urandom), 4'($urandom), 2'($urandom));
      set_req(1, v1, 4'($urandom), 4'($urandom), 2'($urandom));
      #1;
      chk("rnd_busy", busy, cyc < next_free);
      if (cyc >= next_free && (v0 || v1)) begin
        w = (v0 && v1) ? ~last_g : v1;
        chk("rnd_ready", {req0_ready, req1_ready}, {!w, w});
        exp_q.push_back(w ? alu_ref(req1_a, req1_b, req1_sel) : alu_ref(req0_a, req0_b, req0_sel));
        last_g = w;
        if (w) n_g1++; else n_g0++;
        rsp_due = cyc + 2;
        next_free = cyc + 3;
      end else begin
        chk("rnd_not_ready", {req0_ready, req1_ready}, 0);
      end
    end
    chk("rnd_queue_empty", exp_q.size(), 0);

`ifdef ALU_ARB_STATS_EN
    chk("stats_rnd0", grant_cnt0, n_g0 % 256);
    chk("stats_rnd1", grant_cnt1, n_g1 % 256);
    do_reset();
    chk("stats_rst", {grant_cnt0, grant_cnt1}, 0);
    for (int i = 0; i < 3; i++) run_op(0, 4'd1, 4'd1, 2'b00, 4'd2, 1'b0, "stats_r0");
    for (int i = 0; i < 2; i++) run_op(1, 4'd1, 4'd1, 2'b10, 4'd1, 1'b0, "stats_r1");
    chk("stats_cnt0", grant_cnt0, 3);
    chk("stats_cnt1", grant_cnt1, 2);
    for (int i = 0; i < 253; i++) run_op(0, 4'd2, 4'd1, 2'b11, 4'd3, 1'b0, "stats_wrap");
    chk("stats_wrap_cnt0", grant_cnt0, 0);
    chk("stats_wrap_cnt1", grant_cnt1, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
